ray_dispatcher: RTL and testbench

RAY_DISPATCHER -- requirements
Module: ray_dispatcher

---
 rtl/ray_dispatcher.sv | 239 +++++++++++++++++++++++
 tb/tb_ray_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_dispatcher.sv
// Ray job dispatcher: hands pixels to idle ray units in raster order and
// serialises their returned colours into framebuffer writes.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

// state    | meaning
// IDLE     | waiting for start_in, camera values latched on acceptance
// DISPATCH | issuing one pixel job per cycle to the lowest eligible unit
// DRAIN    | all pixels issued, waiting for outstanding results to be written
module ray_dispatcher #(
   parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
   parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
   parameter int H_BITS         = `H_BITS,
   parameter int V_BITS         = `V_BITS,
   parameter int NUM_UNITS      = 4,
   parameter int COORD_W        = 16,
   parameter int FP_W           = 32,
   parameter int FP_FRAC        = 16
) (
   input  logic                                           clk_in,
   input  logic                                           rst_n_in,
   input  logic                                           start_in,
   input  logic [3*COORD_W-1:0]                           cam_origin_in,
   input  logic [3*COORD_W-1:0]                           cam_forward_in,
   input  logic [2:0]                                     fractal_sel_in,
   input  logic [NUM_UNITS-1:0]                           unit_ready_in,
   input  logic [H_BITS-1:0]                              unit_hcount_in [NUM_UNITS],
   input  logic [V_BITS-1:0]                              unit_vcount_in [NUM_UNITS],
   input  logic [3:0]                                     unit_color_in  [NUM_UNITS],
   output logic [3*COORD_W-1:0]                           ray_origin_out,
   output logic [3*COORD_W-1:0]                           ray_direction_out,
   output logic [2:0]                                     fractal_sel_out,
   output logic [H_BITS-1:0]                              hcount_out,
   output logic [V_BITS-1:0]                              vcount_out,
   output logic [FP_W-1:0]                                hcount_fp_out,
   output logic [FP_W-1:0]                                vcount_fp_out,
   output logic [NUM_UNITS-1:0]                           unit_valid_out,
   output logic                                           wr_en_out,
   output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] wr_addr_out,
   output logic [3:0]                                     wr_data_out,
   output logic                                           busy_out,
   output logic                                           frame_done_out
);

   localparam int ADDR_W = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT);

   typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_start_acc;
   logic                  w_issue;
   logic                  w_frame_done;
   logic                  w_last_pix;

   logic [3*COORD_W-1:0]  r_cam_origin;
   logic [3*COORD_W-1:0]  r_cam_forward;
   logic [2:0]            r_frac_sel;
   logic [H_BITS-1:0]     r_hcnt;
   logic [V_BITS-1:0]     r_vcnt;

   logic [NUM_UNITS-1:0]  r_outstanding;
   logic [NUM_UNITS-1:0]  r_ready_q;
   logic [NUM_UNITS-1:0]  r_slot_full;
   logic [H_BITS-1:0]     r_slot_h [NUM_UNITS];
   logic [V_BITS-1:0]     r_slot_v [NUM_UNITS];
   logic [3:0]            r_slot_c [NUM_UNITS];

   logic [NUM_UNITS-1:0]  w_elig;
   logic [NUM_UNITS-1:0]  w_iss_oh;
   logic [NUM_UNITS-1:0]  w_done;
   logic [NUM_UNITS-1:0]  w_wr_oh;
   logic [ADDR_W-1:0]     w_wr_addr;
   logic [3:0]            w_wr_data;

   logic [3*COORD_W-1:0]  r_ray_origin;
   logic [3*COORD_W-1:0]  r_ray_dir;
   logic [2:0]            r_sel_out;
   logic [H_BITS-1:0]     r_hcount;
   logic [V_BITS-1:0]     r_vcount;
   logic [FP_W-1:0]       r_hcount_fp;
   logic [FP_W-1:0]       r_vcount_fp;
   logic [NUM_UNITS-1:0]  r_unit_valid;
   logic                  r_wr_en;
   logic [ADDR_W-1:0]     r_wr_addr;
   logic [3:0]            r_wr_data;
   logic                  r_frame_done;

   // A unit with a captured-but-unwritten result is not re-issued, so each
   // slot holds at most one result and can never be overwritten.
   assign w_elig     = unit_ready_in & ~r_outstanding & ~r_slot_full;
   assign w_iss_oh   = w_elig & (~w_elig + NUM_UNITS'(1));
   assign w_done     = r_outstanding & unit_ready_in & ~r_ready_q;
   assign w_wr_oh    = r_slot_full & (~r_slot_full + NUM_UNITS'(1));
   assign w_last_pix = (r_hcnt == H_BITS'(DISPLAY_WIDTH-1)) &&
                       (r_vcnt == V_BITS'(DISPLAY_HEIGHT-1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= ST_IDLE;
      else           r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_start_acc  = 1'b0;
      w_issue      = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_in) begin
               w_start_acc  = 1'b1;
               w_next_state = ST_DISPATCH;
            end
         end
         ST_DISPATCH: begin
            if (|w_elig) begin
               w_issue = 1'b1;
               if (w_last_pix) w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((r_outstanding == '0) && (r_slot_full == '0)) begin
               w_frame_done = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_wr_addr = '0;
      w_wr_data = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (w_wr_oh[i]) begin
            w_wr_addr = ADDR_W'(r_slot_v[i]) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(r_slot_h[i]);
            w_wr_data = r_slot_c[i];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_cam_origin  <= '0;
         r_cam_forward <= '0;
         r_frac_sel    <= '0;
         r_hcnt        <= '0;
         r_vcnt        <= '0;
         r_outstanding <= '0;
         r_ready_q     <= '0;
         r_slot_full   <= '0;
         for (int i = 0; i < NUM_UNITS; i++) begin
            r_slot_h[i] <= '0;
            r_slot_v[i] <= '0;
            r_slot_c[i] <= '0;
         end
         r_ray_origin  <= '0;
         r_ray_dir     <= '0;
         r_sel_out     <= '0;
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_hcount_fp   <= '0;
         r_vcount_fp   <= '0;
         r_unit_valid  <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_done  <= 1'b0;
      end else begin
         r_ready_q    <= unit_ready_in;
         r_unit_valid <= '0;
         r_frame_done <= w_frame_done;

         if (w_start_acc) begin
            r_cam_origin  <= cam_origin_in;
            r_cam_forward <= cam_forward_in;
            r_frac_sel    <= fractal_sel_in;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
         end

         if (w_issue) begin
            r_unit_valid <= w_iss_oh;
            r_ray_origin <= r_cam_origin;
            r_ray_dir    <= r_cam_forward;
            r_sel_out    <= r_frac_sel;
            r_hcount     <= r_hcnt;
            r_vcount     <= r_vcnt;
            r_hcount_fp  <= FP_W'(r_hcnt) << FP_FRAC;
            r_vcount_fp  <= FP_W'(r_vcnt) << FP_FRAC;
            if (r_hcnt == H_BITS'(DISPLAY_WIDTH-1)) begin
               r_hcnt <= '0;
               r_vcnt <= r_vcnt + V_BITS'(1);
            end else begin
               r_hcnt <= r_hcnt + H_BITS'(1);
            end
         end

         r_outstanding <= (r_outstanding | (w_issue ? w_iss_oh : '0)) & ~w_done;
         r_slot_full   <= (r_slot_full & ~w_wr_oh) | w_done;
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_done[i]) begin
               r_slot_h[i] <= unit_hcount_in[i];
               r_slot_v[i] <= unit_vcount_in[i];
               r_slot_c[i] <= unit_color_in[i];
            end
         end

         r_wr_en   <= |r_slot_full;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
      end
   end

   assign ray_origin_out    = r_ray_origin;
   assign ray_direction_out = r_ray_dir;
   assign fractal_sel_out   = r_sel_out;
   assign hcount_out        = r_hcount;
   assign vcount_out        = r_vcount;
   assign hcount_fp_out     = r_hcount_fp;
   assign vcount_fp_out     = r_vcount_fp;
   assign unit_valid_out    = r_unit_valid;
   assign wr_en_out         = r_wr_en;
   assign wr_addr_out       = r_wr_addr;
   assign wr_data_out       = r_wr_data;
   assign busy_out          = (r_state != ST_IDLE);
   assign frame_done_out    = r_frame_done;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher on a 4x2 display with two fixed-latency unit models.
module tb_ray_dispatcher;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int NU = 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [47:0] cam_org, cam_fwd;
   logic [2:0]  sel;
   logic [1:0]  u_ready;
   logic [1:0]  u_h [2];
   logic [0:0]  u_v [2];
   logic [3:0]  u_c [2];

   logic [47:0] ray_origin_out, ray_direction_out;
   logic [2:0]  fractal_sel_out;
   logic [1:0]  hcount_out;
   logic [0:0]  vcount_out;
   logic [31:0] hcount_fp_out, vcount_fp_out;
   logic [1:0]  unit_valid_out;
   logic        wr_en_out;
   logic [2:0]  wr_addr_out;
   logic [3:0]  wr_data_out;
   logic        busy_out, frame_done_out;

   ray_dispatcher #(
      .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(2), .V_BITS(1), .NUM_UNITS(NU)
   ) dut (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
      .cam_origin_in(cam_org), .cam_forward_in(cam_fwd), .fractal_sel_in(sel),
      .unit_ready_in(u_ready), .unit_hcount_in(u_h), .unit_vcount_in(u_v), .unit_color_in(u_c),
      .ray_origin_out(ray_origin_out), .ray_direction_out(ray_direction_out),
      .fractal_sel_out(fractal_sel_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hcount_fp_out(hcount_fp_out), .vcount_fp_out(vcount_fp_out),
      .unit_valid_out(unit_valid_out), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
      .wr_data_out(wr_data_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // unit models: accept a job on unit_valid_out, return it after lat cycles
   logic       u_en   [2];
   int         u_lat  [2];
   logic [3:0] u_col  [2];
   logic       u_busy [2];
   int         u_cnt  [2];
   logic [1:0] u_jh   [2];
   logic [0:0] u_jv   [2];

   always @(negedge clk) begin
      for (int i = 0; i < NU; i++) begin
         if (!u_en[i]) begin
            u_ready[i] = 1'b0;
         end else if (!u_busy[i]) begin
            if (unit_valid_out[i]) begin
               u_busy[i]  = 1'b1;
               u_cnt[i]   = u_lat[i];
               u_jh[i]    = hcount_out;
               u_jv[i]    = vcount_out;
               u_ready[i] = 1'b0;
            end else begin
               u_ready[i] = 1'b1;
            end
         end else begin
            u_cnt[i]--;
            if (u_cnt[i] == 0) begin
               u_busy[i]  = 1'b0;
               u_h[i]     = u_jh[i];
               u_v[i]     = u_jv[i];
               u_c[i]     = u_col[i];
               u_ready[i] = 1'b1;
            end
         end
      end
   end

   // scoreboard of expected framebuffer writes plus raster-order job model
   typedef struct {
      logic [2:0] addr;
      logic [3:0] data;
   } wr_t;
   wr_t         sb_q[$];
   logic [2:0]  log_addr[$];
   logic [3:0]  log_data[$];
   int          log_cyc[$];
   int          cyc = 0;
   int          disp_cnt, disp_u1, done_cnt, mon_idx;
   logic [1:0]  exp_h;
   logic [0:0]  exp_v;
   logic [47:0] exp_org, exp_fwd;
   logic [2:0]  exp_sel;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n && wr_en_out) begin
         mon_idx = -1;
         foreach (sb_q[k]) if (mon_idx < 0 && sb_q[k].addr == wr_addr_out) mon_idx = k;
         log_addr.push_back(wr_addr_out);
         log_data.push_back(wr_data_out);
         log_cyc.push_back(cyc);
         check("wr_addr_expected", 64'(mon_idx >= 0), 1);
         if (mon_idx >= 0) begin
            check("wr_data", wr_data_out, sb_q[mon_idx].data);
            sb_q.delete(mon_idx);
         end
      end
      if (rst_n && unit_valid_out != '0) begin
         check("valid_onehot", 64'($onehot(unit_valid_out)), 1);
         check("job_h", hcount_out, exp_h);
         check("job_v", vcount_out, exp_v);
         check("job_hfp", hcount_fp_out, 32'(exp_h) << 16);
         check("job_vfp", vcount_fp_out, 32'(exp_v) << 16);
         check("job_origin", ray_origin_out, exp_org);
         check("job_dir", ray_direction_out, exp_fwd);
         check("job_sel", fractal_sel_out, exp_sel);
         disp_cnt++;
         if (unit_valid_out[1]) disp_u1++;
         if (exp_h == 2'(W-1)) begin
            exp_h = '0;
            exp_v = exp_v + 1'b1;
         end else begin
            exp_h = exp_h + 1'b1;
         end
      end
      if (frame_done_out) done_cnt++;
   end

   task automatic clear_logs();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
      disp_cnt = 0;
      disp_u1  = 0;
      done_cnt = 0;
   endtask

   task automatic start_frame(input logic [47:0] org, input logic [47:0] fwd,
                              input logic [2:0] s, input logic [3:0] c_even,
                              input logic [3:0] c_odd);
      @(negedge clk);
      clear_logs();
      sb_q.delete();
      for (int a = 0; a < W*H; a++) begin
         wr_t e;
         e.addr = 3'(a);
         e.data = (a % 2 == 0) ? c_even : c_odd;
         sb_q.push_back(e);
      end
      exp_h   = '0;
      exp_v   = '0;
      exp_org = org;
      exp_fwd = fwd;
      exp_sel = s;
      cam_org = org;
      cam_fwd = fwd;
      sel     = s;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      cam_org = ~org;
      cam_fwd = org ^ fwd ^ 48'h5a5a;
      sel     = ~s;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!frame_done_out && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(k < 3000), 1);
      repeat (5) @(negedge clk);
   endtask

   task automatic frame_checks();
      check("sb_empty", sb_q.size(), 0);
      check("write_count", log_addr.size(), 8);
      check("dispatch_count", disp_cnt, 8);
      check("done_pulses", done_cnt, 1);
      check("busy_after_frame", busy_out, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cam_org = '0;
      cam_fwd = '0;
      sel = '0;
      u_ready = '0;
      exp_h = '0;
      exp_v = '0;
      exp_org = '0;
      exp_fwd = '0;
      exp_sel = '0;
      disp_cnt = 0;
      disp_u1 = 0;
      done_cnt = 0;
      for (int i = 0; i < NU; i++) begin
         u_en[i] = 1'b1; u_lat[i] = 5; u_col[i] = 4'd7; u_busy[i] = 1'b0;
         u_cnt[i] = 0; u_jh[i] = '0; u_jv[i] = '0;
         u_h[i] = '0; u_v[i] = '0; u_c[i] = '0;
      end
      #12;
      check("rst_busy", busy_out, 0);
      check("rst_valid", unit_valid_out, 0);
      check("rst_wr_en", wr_en_out, 0);
      check("rst_wr_addr", wr_addr_out, 0);
      check("rst_done", frame_done_out, 0);
      check("rst_origin", ray_origin_out, 0);
      check("rst_hcount", hcount_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // full frame, both units latency 5, colour 7
      start_frame(48'h0001_0002_0003, 48'h0000_0000_0100, 3'd5, 4'd7, 4'd7);
      check("busy_in_frame", busy_out, 1);
      wait_done("frame_a_timeout");
      frame_checks();

      // simultaneous completions: unit0 latency 6, unit1 latency 5
      u_lat[0] = 6; u_col[0] = 4'd2;
      u_lat[1] = 5; u_col[1] = 4'd5;
      start_frame(48'h1111_2222_3333, 48'h0abc_0def_0123, 3'd2, 4'd2, 4'd5);
      wait_done("frame_b_timeout");
      frame_checks();
      if (log_addr.size() >= 2) begin
         check("simul_first_addr", log_addr[0], 0);
         check("simul_first_data", log_data[0], 2);
         check("simul_second_addr", log_addr[1], 1);
         check("simul_second_data", log_data[1], 5);
         check("simul_consecutive", log_cyc[1] - log_cyc[0], 1);
      end else begin
         check("simul_write_pair", log_addr.size(), 2);
      end

      // unit 1 never ready; start re-pulsed mid-frame must be ignored
      u_en[1] = 1'b0;
      u_lat[0] = 5; u_col[0] = 4'd4;
      repeat (2) @(negedge clk);
      start_frame(48'h0f0f_f0f0_1234, 48'h4321_0000_ffff, 3'd7, 4'd4, 4'd4);
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("frame_c_timeout");
      frame_checks();
      check("unit1_jobs", disp_u1, 0);

      // spurious ready rise while idle
      clear_logs();
      u_en[1] = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_rise_writes", log_addr.size(), 0);
      check("idle_rise_jobs", disp_cnt, 0);
      check("idle_rise_busy", busy_out, 0);

      // reset after three dispatches abandons the frame
      u_lat[0] = 5; u_col[0] = 4'd7;
      u_lat[1] = 5; u_col[1] = 4'd7;
      start_frame(48'h0000_7777_0000, 48'h0000_0000_8888, 3'd1, 4'd7, 4'd7);
      begin
         int k;
         k = 0;
         while (disp_cnt < 3 && k < 500) begin
            @(negedge clk);
            k++;
         end
         check("abort_dispatch_timeout", 64'(k < 500), 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy_out, 0);
      check("async_rst_valid", unit_valid_out, 0);
      check("async_rst_wr_en", wr_en_out, 0);
      sb_q.delete();
      clear_logs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_writes", log_addr.size(), 0);
      check("abort_done", done_cnt, 0);
      check("abort_busy", busy_out, 0);
      start_frame(48'h0102_0304_0506, 48'h0a0b_0c0d_0e0f, 3'd3, 4'd7, 4'd7);
      wait_done("frame_e_timeout");
      frame_checks();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
